priority_resolver_n: RTL and testbench
======================================

Name: priority_resolver_n

Overview:
Parametrised, fully synchronous successor of the interrupt priority resolver. Accepts NUM_IRQ request lines and latches them into the IRR in edge- or level-triggered mode. Arbitrates with fixed or rotating priority and fully nested ISR blocking, and runs the two-pulse INTA acknowledge sequence that delivers a vector index. Sits between the I/O request lines, the control/command decoder (mask and EOI commands) and the CPU interface.

Parameters:
NUM_IRQ, 8, number of interrupt request channels (2..32)
IDX_W, 3, width of a channel index; must equal ceil(log2(NUM_IRQ))

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
ltim  in  1  1 = level-triggered IRR, 0 = edge-triggered IRR
ir  in  NUM_IRQ  request lines, synchronous to clk
imr_wr  in  1  one-cycle strobe: load imr from imr_data
imr_data  in  NUM_IRQ  new mask value
cmd_valid  in  1  one-cycle strobe for an EOI/priority command
cmd_op  in  3  0 nonspecific EOI, 1 specific EOI, 2 rotate-on-nonspecific EOI, 3 rotate-on-specific EOI, 4 set lowest priority, others no-op
cmd_level  in  IDX_W  channel operand for ops 1, 3, 4
aeoi  in  1  automatic EOI on second INTA
rotate_aeoi  in  1  with aeoi, rotate priority on automatic EOI
inta_n  in  1  CPU acknowledge, active low, synchronous to clk
int  out  1  interrupt request to CPU
int_vec  out  IDX_W  acknowledged channel index
vec_valid  out  1  one-cycle pulse with int_vec on second INTA
irr  out  NUM_IRQ  interrupt request register
isr  out  NUM_IRQ  in-service register
imr  out  NUM_IRQ  interrupt mask register

Behaviour:
- Reset values: irr=0, isr=0, imr=0, int=0, int_vec=0, vec_valid=0. Bottom-priority pointer lowest_pri=NUM_IRQ-1, so channel 0 is highest. FSM=IDLE. ir_q=0 and inta_q=1 (internal sample registers).
- Priority order: channel (lowest_pri+1) mod NUM_IRQ is highest, stepping upward with wrap-around; lowest_pri is lowest.
- IRR, edge mode: bit set at a clk edge where ir=1 and ir_q=0. It stays set until acknowledged or ir=0 is sampled.
- IRR, level mode: each bit follows ir with 1-cycle latency.
- Same-cycle conflict: if an ack clear and a new rising edge hit the same bit, the set wins.
- int (combinational from registers): 1 iff some bit of irr & ~imr has priority strictly higher than the highest-priority set isr bit (any bit when isr=0). Latency from ir rise to int is 1 cycle.
- imr_wr takes effect on the next edge. Masking never clears irr.
- Acknowledge FSM (INTA falling edge = inta_q=1 and inta_n=0 at a clk edge):
  - IDLE -> ACK1 on first falling edge. The winner is the highest-priority bit of irr & ~imr; the index is frozen into sel, isr[sel] is set and irr[sel] (edge mode) is cleared.
  - Spurious ack: if no candidate exists, sel=NUM_IRQ-1 and isr/irr are untouched.
  - ACK1 -> IDLE on second falling edge: int_vec=sel and vec_valid=1 for exactly one cycle.
  - If aeoi=1 (not on a spurious ack), isr[sel] is cleared. If rotate_aeoi=1 as well, lowest_pri=sel.
- EOI commands (cmd_valid):
  - op0: clear the highest-priority set isr bit; no-op if isr=0.
  - op2: as op0, plus lowest_pri becomes that index.
  - op1: clear isr[cmd_level]. op3: as op1, plus lowest_pri=cmd_level.
  - op4: lowest_pri=cmd_level, isr untouched.
  - cmd_level >= NUM_IRQ: ignored.
- Simultaneous command and ack in the same cycle: the EOI is applied first, then ack arbitration runs against the post-EOI isr.
- reset asserted mid-sequence returns the FSM to IDLE immediately and clears all state.
- Repeated inta_n low with no falling edge does nothing.

Optional Feature:
PRIORITY_RESOLVER_SMM_EN:
- Defined: adds input smm (1 bit). When smm=1, isr bits whose imr bit is set are ignored when computing int and when selecting the op0/op2 target, so lower-priority channels may interrupt.
- Undefined: no smm port; full nesting as above.

Test Plan:
1. Reset, edge mode, ir=8'b0000_0100 -> irr=0x04 and int=1 one cycle later. Two INTA pulses -> isr=0x04, irr=0, int_vec=2, vec_valid pulses once.
2. ir=0x0A (channels 1,3) with isr=0 -> first ack serves 1. While isr=0x02, int=0 for channel 3. op0 EOI -> isr=0, int=1, next ack int_vec=3.
3. aeoi=1, rotate_aeoi=1, ir=0x01 pulse -> after ack isr=0 and lowest_pri=0. Then ir=0x81 -> next ack int_vec=7.
4. imr_data=0xFF with ir=0x10 -> int=0 and irr=0x10. INTA pair -> spurious ack: int_vec=7, isr=0.
5. Level mode: ir=0x20 then 0 before INTA -> irr returns to 0 and int drops after 1 cycle. op4 with cmd_level=3 -> channel 4 is highest.
6. Assert reset between the two INTA pulses -> all outputs 0 and no vec_valid. A following INTA pair starts a fresh sequence.

Source files
------------

// File: rtl/priority_resolver_n_if.sv
// priority_resolver_n_if: request/command/acknowledge bus of priority_resolver_n
// slave = resolver side, master = driver side. The optional i_smm line exists only
// when PRIORITY_RESOLVER_SMM_EN is defined.
interface priority_resolver_n_if #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
);
  logic               i_ltim;
  logic [NUM_IRQ-1:0] i_ir;
  logic               i_imr_wr;
  logic [NUM_IRQ-1:0] i_imr_data;
  logic               i_cmd_valid;
  logic [2:0]         i_cmd_op;
  logic [IDX_W-1:0]   i_cmd_level;
  logic               i_aeoi;
  logic               i_rotate_aeoi;
  logic               i_inta_n;
`ifdef PRIORITY_RESOLVER_SMM_EN
  logic               i_smm;
`endif
  logic               o_int;
  logic [IDX_W-1:0]   o_int_vec;
  logic               o_vec_valid;
  logic [NUM_IRQ-1:0] o_irr;
  logic [NUM_IRQ-1:0] o_isr;
  logic [NUM_IRQ-1:0] o_imr;
  modport slave (
`ifdef PRIORITY_RESOLVER_SMM_EN
    input  i_smm,
`endif
    input  i_ltim, i_ir, i_imr_wr, i_imr_data, i_cmd_valid, i_cmd_op, i_cmd_level,
    input  i_aeoi, i_rotate_aeoi, i_inta_n,
    output o_int, o_int_vec, o_vec_valid, o_irr, o_isr, o_imr
  );
  modport master (
`ifdef PRIORITY_RESOLVER_SMM_EN
    output i_smm,
`endif
    output i_ltim, i_ir, i_imr_wr, i_imr_data, i_cmd_valid, i_cmd_op, i_cmd_level,
    output i_aeoi, i_rotate_aeoi, i_inta_n,
    input  o_int, o_int_vec, o_vec_valid, o_irr, o_isr, o_imr
  );
endinterface

// File: rtl/priority_resolver_n.sv
// priority_resolver_n: parametrised interrupt priority resolver with nested ISR and two-pulse INTA
// Ports: clk, reset (async, active high), bus (priority_resolver_n_if.slave):
//   inputs  ltim/ir/imr_wr/imr_data/cmd_valid/cmd_op/cmd_level/aeoi/rotate_aeoi/inta_n
//   outputs int/int_vec/vec_valid/irr/isr/imr
// Optional: PRIORITY_RESOLVER_SMM_EN adds i_smm (special mask mode).
module priority_resolver_n #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
) (
  input logic clk,
  input logic reset,
  priority_resolver_n_if.slave bus
);
  typedef enum logic {IDLE, ACK1} state_t;
  typedef struct packed {
    logic             f;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rank;
  } pick_t;
  // Highest-priority set bit of v; rank 0 is channel lp+1 (mod NUM_IRQ).
  function automatic pick_t pick(input logic [NUM_IRQ-1:0] v, input logic [IDX_W-1:0] lp);
    pick_t p;
    int c;
    p = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      c = int'(lp) + 1 + k;
      if (c >= NUM_IRQ) c -= NUM_IRQ;
      if (v[c]) begin
        p.f = 1'b1;
        p.idx = IDX_W'(c);
        p.rank = IDX_W'(k);
      end
    end
    return p;
  endfunction
  state_t             r_state;
  logic [NUM_IRQ-1:0] r_ir_q, r_irr, r_isr, r_imr;
  logic               r_inta_q, r_vec_valid, r_spur;
  logic [IDX_W-1:0]   r_lowest_pri, r_sel, r_int_vec;
  logic [NUM_IRQ-1:0] w_cand, w_isr_eff, w_isr_e, w_isr_n, w_clr, w_irr_n;
  logic [IDX_W-1:0]   w_lp_e, w_lp_n;
  logic               w_fall, w_lvl_ok;
  pick_t              w_cp, w_ip, w_ap;
  always_comb begin
`ifdef PRIORITY_RESOLVER_SMM_EN
    w_isr_eff = bus.i_smm ? r_isr & ~r_imr : r_isr;
`else
    w_isr_eff = r_isr;
`endif
    w_cand = r_irr & ~r_imr;
    w_cp = pick(w_cand, r_lowest_pri);
    w_ip = pick(w_isr_eff, r_lowest_pri);
    w_fall = r_inta_q & ~bus.i_inta_n;
    w_lvl_ok = int'(bus.i_cmd_level) < NUM_IRQ;
    w_isr_e = r_isr;
    w_lp_e = r_lowest_pri;
    if (bus.i_cmd_valid) begin
      if ((bus.i_cmd_op == 3'd0 || bus.i_cmd_op == 3'd2) && w_ip.f) begin
        w_isr_e[w_ip.idx] = 1'b0;
        w_lp_e = bus.i_cmd_op == 3'd2 ? w_ip.idx : w_lp_e;
      end
      if ((bus.i_cmd_op == 3'd1 || bus.i_cmd_op == 3'd3) && w_lvl_ok) begin
        w_isr_e[bus.i_cmd_level] = 1'b0;
        w_lp_e = bus.i_cmd_op == 3'd3 ? bus.i_cmd_level : w_lp_e;
      end
      if (bus.i_cmd_op == 3'd4 && w_lvl_ok) w_lp_e = bus.i_cmd_level;
    end
    // Acknowledge arbitration sees the post-EOI state.
    w_ap = pick(w_cand, w_lp_e);
    w_isr_n = w_isr_e;
    w_lp_n = w_lp_e;
    w_clr = '0;
    if (w_fall && r_state == IDLE && w_ap.f) begin
      w_isr_n[w_ap.idx] = 1'b1;
      w_clr[w_ap.idx] = ~bus.i_ltim;
    end
    if (w_fall && r_state == ACK1 && bus.i_aeoi && !r_spur) begin
      w_isr_n[r_sel] = 1'b0;
      w_lp_n = bus.i_rotate_aeoi ? r_sel : w_lp_n;
    end
    // A fresh rising edge beats an acknowledge clear on the same bit.
    w_irr_n = bus.i_ltim ? bus.i_ir : (bus.i_ir & ~r_ir_q) | (r_irr & bus.i_ir & ~w_clr);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ir_q <= '0;
      r_inta_q <= 1'b1;
      r_irr <= '0;
      r_isr <= '0;
      r_imr <= '0;
      r_lowest_pri <= IDX_W'(NUM_IRQ - 1);
      r_sel <= '0;
      r_spur <= 1'b0;
      r_int_vec <= '0;
      r_vec_valid <= 1'b0;
    end else begin
      r_ir_q <= bus.i_ir;
      r_inta_q <= bus.i_inta_n;
      r_irr <= w_irr_n;
      r_isr <= w_isr_n;
      r_imr <= bus.i_imr_wr ? bus.i_imr_data : r_imr;
      r_lowest_pri <= w_lp_n;
      r_vec_valid <= 1'b0;
      if (w_fall && r_state == IDLE) begin
        r_sel <= w_ap.f ? w_ap.idx : IDX_W'(NUM_IRQ - 1);
        r_spur <= ~w_ap.f;
        r_state <= ACK1;
      end
      if (w_fall && r_state == ACK1) begin
        r_int_vec <= r_sel;
        r_vec_valid <= 1'b1;
        r_state <= IDLE;
      end
    end
  end
  assign bus.o_int = w_cp.f && (!w_ip.f || w_cp.rank < w_ip.rank);
  assign bus.o_int_vec = r_int_vec;
  assign bus.o_vec_valid = r_vec_valid;
  assign bus.o_irr = r_irr;
  assign bus.o_isr = r_isr;
  assign bus.o_imr = r_imr;
endmodule

// File: tb/tb_priority_resolver_n.sv
// tb_priority_resolver_n: directed self-checking bench for priority_resolver_n
module tb_priority_resolver_n;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  priority_resolver_n_if #(.NUM_IRQ(8), .IDX_W(3)) bus ();
  priority_resolver_n #(.NUM_IRQ(8), .IDX_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.i_ir = '0;
    bus.i_inta_n = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_imr_wr = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask
  task automatic inta(input logic v);
    bus.i_inta_n = v;
    tick();
  endtask
  task automatic cmd(input logic [2:0] op, input logic [2:0] lvl);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op = op;
    bus.i_cmd_level = lvl;
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask
  initial begin
    bus.i_ltim = 1'b0;
    bus.i_ir = '0;
    bus.i_imr_wr = 1'b0;
    bus.i_imr_data = '0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op = '0;
    bus.i_cmd_level = '0;
    bus.i_aeoi = 1'b0;
    bus.i_rotate_aeoi = 1'b0;
    bus.i_inta_n = 1'b1;
`ifdef PRIORITY_RESOLVER_SMM_EN
    bus.i_smm = 1'b0;
`endif
    #1;
    tick();
    chk("rst_irr", 32'(bus.o_irr), 0);
    chk("rst_isr", 32'(bus.o_isr), 0);
    chk("rst_imr", 32'(bus.o_imr), 0);
    chk("rst_int", 32'(bus.o_int), 0);
    chk("rst_vec", 32'(bus.o_int_vec), 0);
    chk("rst_vv", 32'(bus.o_vec_valid), 0);
    reset = 1'b0;
    tick();
    bus.i_ir = 8'h04;
    tick();
    chk("t1_irr", 32'(bus.o_irr), 32'h04);
    chk("t1_int", 32'(bus.o_int), 1);
    inta(1'b0);
    chk("t1_isr", 32'(bus.o_isr), 32'h04);
    chk("t1_irr_clr", 32'(bus.o_irr), 0);
    chk("t1_vv_ack1", 32'(bus.o_vec_valid), 0);
    inta(1'b1);
    inta(1'b0);
    chk("t1_vv", 32'(bus.o_vec_valid), 1);
    chk("t1_vec", 32'(bus.o_int_vec), 2);
    inta(1'b1);
    chk("t1_vv_drop", 32'(bus.o_vec_valid), 0);
    do_reset();
    bus.i_ir = 8'h0A;
    tick();
    chk("t2_int", 32'(bus.o_int), 1);
    inta(1'b0);
    chk("t2_isr", 32'(bus.o_isr), 32'h02);
    chk("t2_irr", 32'(bus.o_irr), 32'h08);
    chk("t2_blocked", 32'(bus.o_int), 0);
    tick();
    chk("t2_hold_low", 32'(bus.o_vec_valid), 0);
    inta(1'b1);
    inta(1'b0);
    chk("t2_vec1", 32'(bus.o_int_vec), 1);
    inta(1'b1);
    cmd(3'd0, 3'd0);
    chk("t2_eoi_isr", 32'(bus.o_isr), 0);
    chk("t2_eoi_int", 32'(bus.o_int), 1);
    inta(1'b0);
    inta(1'b1);
    inta(1'b0);
    chk("t2_vec3", 32'(bus.o_int_vec), 3);
    chk("t2_vv3", 32'(bus.o_vec_valid), 1);
    inta(1'b1);
    do_reset();
    bus.i_aeoi = 1'b1;
    bus.i_rotate_aeoi = 1'b1;
    bus.i_ir = 8'h01;
    tick();
    inta(1'b0);
    bus.i_ir = 8'h00;
    inta(1'b1);
    inta(1'b0);
    chk("t3_vec0", 32'(bus.o_int_vec), 0);
    chk("t3_aeoi_isr", 32'(bus.o_isr), 0);
    inta(1'b1);
    bus.i_ir = 8'h81;
    tick();
    inta(1'b0);
    chk("t3_isr7", 32'(bus.o_isr), 32'h80);
    inta(1'b1);
    inta(1'b0);
    chk("t3_vec7", 32'(bus.o_int_vec), 7);
    inta(1'b1);
    bus.i_aeoi = 1'b0;
    bus.i_rotate_aeoi = 1'b0;
    do_reset();
    bus.i_imr_wr = 1'b1;
    bus.i_imr_data = 8'hFF;
    tick();
    bus.i_imr_wr = 1'b0;
    chk("t4_imr", 32'(bus.o_imr), 32'hFF);
    bus.i_ir = 8'h10;
    tick();
    chk("t4_irr", 32'(bus.o_irr), 32'h10);
    chk("t4_int", 32'(bus.o_int), 0);
    inta(1'b0);
    chk("t4_spur_isr", 32'(bus.o_isr), 0);
    chk("t4_spur_irr", 32'(bus.o_irr), 32'h10);
    inta(1'b1);
    inta(1'b0);
    chk("t4_vec", 32'(bus.o_int_vec), 7);
    chk("t4_vv", 32'(bus.o_vec_valid), 1);
    inta(1'b1);
    do_reset();
    bus.i_imr_data = 8'h00;
    bus.i_ltim = 1'b1;
    bus.i_ir = 8'h20;
    tick();
    chk("t5_irr", 32'(bus.o_irr), 32'h20);
    chk("t5_int", 32'(bus.o_int), 1);
    bus.i_ir = 8'h00;
    tick();
    chk("t5_irr0", 32'(bus.o_irr), 0);
    chk("t5_int0", 32'(bus.o_int), 0);
    cmd(3'd4, 3'd3);
    bus.i_ir = 8'h11;
    tick();
    inta(1'b0);
    chk("t5_isr4", 32'(bus.o_isr), 32'h10);
    chk("t5_lvl_irr", 32'(bus.o_irr), 32'h11);
    inta(1'b1);
    inta(1'b0);
    chk("t5_vec4", 32'(bus.o_int_vec), 4);
    inta(1'b1);
    cmd(3'd1, 3'd4);
    chk("t5_spec_eoi", 32'(bus.o_isr), 0);
    bus.i_ltim = 1'b0;
    do_reset();
    bus.i_ir = 8'h04;
    tick();
    inta(1'b0);
    inta(1'b1);
    reset = 1'b1;
    #1;
    chk("t6_irr", 32'(bus.o_irr), 0);
    chk("t6_isr", 32'(bus.o_isr), 0);
    chk("t6_int", 32'(bus.o_int), 0);
    chk("t6_vv", 32'(bus.o_vec_valid), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_irr_new", 32'(bus.o_irr), 32'h04);
    inta(1'b0);
    chk("t6_fresh_vv", 32'(bus.o_vec_valid), 0);
    chk("t6_fresh_isr", 32'(bus.o_isr), 32'h04);
    inta(1'b1);
    inta(1'b0);
    chk("t6_vv2", 32'(bus.o_vec_valid), 1);
    chk("t6_vec2", 32'(bus.o_int_vec), 2);
    inta(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
